tile_match_engine: RTL

//  Game-side initiator for the dual-port tile RAM (ports A/B on gameClk). Takes player tile

---
 rtl/tile_match_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tile_match_engine.sv
// tile_match_engine
//   Game-side initiator for the dual-port tile RAM. Takes two player selections, reads both
//   tiles' colours, then either blanks the pair in RAM (match) or shows both tiles for
//   MISS_HOLD cycles before hiding them again (miss). Keeps the reveal/matched masks for the
//   video overlay and the pair score.
// Ports
//   gameClk, reset          clock and asynchronous active-high reset
//   selValid, selIdx        one-cycle selection pulse and tile index 0..15
//   addrA/addrB             RAM addresses (first / second selected tile)
//   writeA/writeB, weA/weB  RAM write data (always BLANK) and write enables
//   readA/readB             RAM read data, one-cycle registered latency
//   revealMask/matchedMask  face-up tiles / matched tiles
//   busy                    selections ignored while high
//   matchPulse/missPulse    one-cycle outcome strobes
//   score, gameDone         pairs matched; gameDone while score == PAIRS
module tile_match_engine #(
  parameter int unsigned MISS_HOLD = 25_000_000,
  parameter logic [7:0]  BLANK     = 8'h00,
  parameter int unsigned PAIRS     = 8
) (
  input  logic        gameClk,
  input  logic        reset,
  input  logic        selValid,
  input  logic [3:0]  selIdx,
  output logic [3:0]  addrA,
  output logic [3:0]  addrB,
  output logic [7:0]  writeA,
  output logic [7:0]  writeB,
  output logic        weA,
  output logic        weB,
  input  logic [7:0]  readA,
  input  logic [7:0]  readB,
  output logic [15:0] revealMask,
  output logic [15:0] matchedMask,
  output logic        busy,
  output logic        matchPulse,
  output logic        missPulse,
  output logic [3:0]  score,
  output logic        gameDone
);

  localparam int unsigned HoldW = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(MISS_HOLD - 1);
  localparam logic [3:0] PairsCnt = 4'(PAIRS);

  typedef enum logic [2:0] {
    StIdle, StOneUp, StFetch, StCmp, StClear, StShow
  } stateE;

  stateE            stateQ, stateD;
  logic [3:0]       firstIdxQ, firstIdxD;
  logic [3:0]       secondIdxQ, secondIdxD;
  logic [15:0]      revealQ, revealD;
  logic [15:0]      matchedQ, matchedD;
  logic [3:0]       scoreQ, scoreD;
  logic [HoldW-1:0] holdQ, holdD;

  logic [15:0] selBit;
  logic [15:0] pairBits;
  logic        selOk;

  assign selBit   = 16'h0001 << selIdx;
  assign pairBits = (16'h0001 << firstIdxQ) | (16'h0001 << secondIdxQ);
  // State gating (IDLE/ONE_UP) is applied in the FSM below.
  assign selOk    = selValid && !gameDone && !matchedQ[selIdx] && !revealQ[selIdx];

  always_ff @(posedge gameClk or posedge reset) begin
    if (reset) begin
      stateQ     <= StIdle;
      firstIdxQ  <= 4'd0;
      secondIdxQ <= 4'd0;
      revealQ    <= 16'h0000;
      matchedQ   <= 16'h0000;
      scoreQ     <= 4'd0;
      holdQ      <= '0;
    end else begin
      stateQ     <= stateD;
      firstIdxQ  <= firstIdxD;
      secondIdxQ <= secondIdxD;
      revealQ    <= revealD;
      matchedQ   <= matchedD;
      scoreQ     <= scoreD;
      holdQ      <= holdD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    firstIdxD  = firstIdxQ;
    secondIdxD = secondIdxQ;
    revealD    = revealQ;
    matchedD   = matchedQ;
    scoreD     = scoreQ;
    holdD      = holdQ;
    busy       = 1'b0;
    weA        = 1'b0;
    weB        = 1'b0;
    matchPulse = 1'b0;
    missPulse  = 1'b0;

    case (stateQ)
      StIdle: begin
        if (selOk) begin
          firstIdxD = selIdx;
          revealD   = revealQ | selBit;
          stateD    = StOneUp;
        end
      end
      StOneUp: begin
        if (selOk) begin
          secondIdxD = selIdx;
          revealD    = revealQ | selBit;
          stateD     = StFetch;
        end
      end
      StFetch: begin
        // Addresses are stable this cycle; RAM registers both colours at its end.
        busy   = 1'b1;
        stateD = StCmp;
      end
      StCmp: begin
        busy = 1'b1;
        if (readA == readB) begin
          stateD = StClear;
        end else begin
          holdD  = HoldLoad;
          stateD = StShow;
        end
      end
      StClear: begin
        // The two indices always differ, so both ports never write the same word.
        busy       = 1'b1;
        weA        = 1'b1;
        weB        = 1'b1;
        matchPulse = 1'b1;
        matchedD   = matchedQ | pairBits;
        revealD    = revealQ & ~pairBits;
        if (scoreQ < PairsCnt) begin
          scoreD = scoreQ + 4'd1;
        end
        stateD = StIdle;
      end
      StShow: begin
        busy = 1'b1;
        // Counter only equals its load value on the first SHOW cycle.
        missPulse = (holdQ == HoldLoad);
        if (holdQ == '0) begin
          revealD = revealQ & ~pairBits;
          stateD  = StIdle;
        end else begin
          holdD = holdQ - 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  assign addrA       = firstIdxQ;
  assign addrB       = secondIdxQ;
  assign writeA      = BLANK;
  assign writeB      = BLANK;
  assign revealMask  = revealQ;
  assign matchedMask = matchedQ;
  assign score       = scoreQ;
  assign gameDone    = (scoreQ == PairsCnt);

endmodule
